// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with immediate extension, EX operand forwarding
// and hazard bubbles. Optional forwarding build: define EX_FORWARD_EN.
module id_ex_stage #(
   parameter int N = 32,
   parameter int R = 5
) (
   input  logic         input_clk,
   input  logic         input_reset,
   input  logic         input_stall,
   input  logic         input_flush,
   input  logic         input_valid,
   input  logic [N-1:0] input_busa,
   input  logic [N-1:0] input_busb,
   input  logic [15:0]  input_imm16,
   input  logic         input_extop,
   input  logic [R-1:0] input_rs,
   input  logic [R-1:0] input_rt,
   input  logic [R-1:0] input_rd,
   input  logic [2:0]   input_aluctr,
   input  logic         input_alusrc,
   input  logic         input_regdst,
   input  logic         input_regwr,
   input  logic         input_memrd,
   input  logic         input_memwr,
   input  logic         input_memtoreg,
   input  logic         input_exmem_regwr,
   input  logic [R-1:0] input_exmem_rw,
   input  logic [N-1:0] input_exmem_result,
   input  logic         input_memwb_regwr,
   input  logic [R-1:0] input_memwb_rw,
   input  logic [N-1:0] input_memwb_data,
   output logic [N-1:0] out_alu_a,
   output logic [N-1:0] out_alu_b,
   output logic [2:0]   out_aluctr,
   output logic [N-1:0] out_store_data,
   output logic [R-1:0] out_rw,
   output logic         out_regwr,
   output logic         out_memrd,
   output logic         out_memwr,
   output logic         out_memtoreg,
   output logic         out_valid,
   output logic         out_hazard_stall
);

   logic [N-1:0] busa_q, busb_q, imm_q;
   logic [R-1:0] rs_q, rt_q, rw_q;
   logic [2:0]   aluctr_q;
   logic         alusrc_q, regwr_q, memrd_q, memwr_q, memtoreg_q, valid_q;

   logic [N-1:0] ext_imm, val_a, val_b;
   logic [R-1:0] rw_d;
   logic         hazard;

   assign ext_imm = input_extop ?
      {{(N-16){input_imm16[15]}}, input_imm16} :
      {{(N-16){1'b0}}, input_imm16};
   assign rw_d = input_regdst ? input_rd : input_rt;

`ifdef EX_FORWARD_EN
   // EX/MEM holds the newer value, so it is checked first
   assign val_a =
      (input_exmem_regwr && input_exmem_rw == rs_q && rs_q != '0) ?
         input_exmem_result :
      (input_memwb_regwr && input_memwb_rw == rs_q && rs_q != '0) ?
         input_memwb_data : busa_q;
   assign val_b =
      (input_exmem_regwr && input_exmem_rw == rt_q && rt_q != '0) ?
         input_exmem_result :
      (input_memwb_regwr && input_memwb_rw == rt_q && rt_q != '0) ?
         input_memwb_data : busb_q;
   assign hazard = valid_q && memrd_q && rw_q != '0 && input_valid &&
                   (rw_q == input_rs || rw_q == input_rt);
`else
   logic hit_rs, hit_rt;
   logic unused_fwd;

   assign val_a = busa_q;
   assign val_b = busb_q;
   // Without forwarding, any pending writer of a source must drain first
   assign hit_rs = input_rs != '0 &&
      ((valid_q && regwr_q && rw_q == input_rs) ||
       (input_exmem_regwr && input_exmem_rw == input_rs));
   assign hit_rt = input_rt != '0 &&
      ((valid_q && regwr_q && rw_q == input_rt) ||
       (input_exmem_regwr && input_exmem_rw == input_rt));
   assign hazard = input_valid && (hit_rs || hit_rt);
   assign unused_fwd = ^{input_exmem_result, input_memwb_regwr,
                         input_memwb_rw, input_memwb_data,
                         rs_q, rt_q, memrd_q};
`endif

   always_ff @(posedge input_clk) begin
      if (input_reset || input_flush ||
          (!input_stall && hazard)) begin
         busa_q     <= '0;
         busb_q     <= '0;
         imm_q      <= '0;
         rs_q       <= '0;
         rt_q       <= '0;
         rw_q       <= '0;
         aluctr_q   <= '0;
         alusrc_q   <= 1'b0;
         regwr_q    <= 1'b0;
         memrd_q    <= 1'b0;
         memwr_q    <= 1'b0;
         memtoreg_q <= 1'b0;
         valid_q    <= 1'b0;
      end else if (!input_stall) begin
         busa_q     <= input_busa;
         busb_q     <= input_busb;
         imm_q      <= ext_imm;
         rs_q       <= input_rs;
         rt_q       <= input_rt;
         rw_q       <= rw_d;
         aluctr_q   <= input_aluctr;
         alusrc_q   <= input_alusrc;
         regwr_q    <= input_regwr;
         memrd_q    <= input_memrd;
         memwr_q    <= input_memwr;
         memtoreg_q <= input_memtoreg;
         valid_q    <= input_valid;
      end
   end

   assign out_alu_a        = val_a;
   assign out_alu_b        = alusrc_q ? imm_q : val_b;
   assign out_store_data   = val_b;
   assign out_aluctr       = aluctr_q;
   assign out_rw           = rw_q;
   assign out_regwr        = regwr_q;
   assign out_memrd        = memrd_q;
   assign out_memwr        = memwr_q;
   assign out_memtoreg     = memtoreg_q;
   assign out_valid        = valid_q;
   assign out_hazard_stall = hazard;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus a
// randomized run against a behavioural reference model.
module tb_id_ex_stage;

   logic        input_clk = 1'b0;
   logic        input_reset, input_stall, input_flush, input_valid;
   logic [31:0] input_busa, input_busb;
   logic [15:0] input_imm16;
   logic        input_extop;
   logic [4:0]  input_rs, input_rt, input_rd;
   logic [2:0]  input_aluctr;
   logic        input_alusrc, input_regdst, input_regwr;
   logic        input_memrd, input_memwr, input_memtoreg;
   logic        input_exmem_regwr;
   logic [4:0]  input_exmem_rw;
   logic [31:0] input_exmem_result;
   logic        input_memwb_regwr;
   logic [4:0]  input_memwb_rw;
   logic [31:0] input_memwb_data;
   logic [31:0] out_alu_a, out_alu_b, out_store_data;
   logic [2:0]  out_aluctr;
   logic [4:0]  out_rw;
   logic        out_regwr, out_memrd, out_memwr, out_memtoreg;
   logic        out_valid, out_hazard_stall;

   int total = 0;
   int bad = 0;

   id_ex_stage #(.N(32), .R(5)) dut (
      .input_clk(input_clk), .input_reset(input_reset),
      .input_stall(input_stall), .input_flush(input_flush),
      .input_valid(input_valid), .input_busa(input_busa),
      .input_busb(input_busb), .input_imm16(input_imm16),
      .input_extop(input_extop), .input_rs(input_rs),
      .input_rt(input_rt), .input_rd(input_rd),
      .input_aluctr(input_aluctr), .input_alusrc(input_alusrc),
      .input_regdst(input_regdst), .input_regwr(input_regwr),
      .input_memrd(input_memrd), .input_memwr(input_memwr),
      .input_memtoreg(input_memtoreg),
      .input_exmem_regwr(input_exmem_regwr),
      .input_exmem_rw(input_exmem_rw),
      .input_exmem_result(input_exmem_result),
      .input_memwb_regwr(input_memwb_regwr),
      .input_memwb_rw(input_memwb_rw),
      .input_memwb_data(input_memwb_data),
      .out_alu_a(out_alu_a), .out_alu_b(out_alu_b),
      .out_aluctr(out_aluctr), .out_store_data(out_store_data),
      .out_rw(out_rw), .out_regwr(out_regwr),
      .out_memrd(out_memrd), .out_memwr(out_memwr),
      .out_memtoreg(out_memtoreg), .out_valid(out_valid),
      .out_hazard_stall(out_hazard_stall)
   );

   always #5 input_clk = ~input_clk;

   // Instruction as held in the stage
   typedef struct packed {
      logic [31:0] busa, busb, imm;
      logic [4:0]  rs, rt, rw;
      logic [2:0]  aluctr;
      logic        alusrc, regwr, memrd, memwr, memtoreg, valid;
   } st_t;

   st_t m;

   task automatic tick;
      @(posedge input_clk);
      #1;
   endtask

   task automatic clear_in;
      input_reset = 0; input_stall = 0; input_flush = 0;
      input_valid = 0; input_busa = 0; input_busb = 0;
      input_imm16 = 0; input_extop = 0; input_rs = 0;
      input_rt = 0; input_rd = 0; input_aluctr = 0;
      input_alusrc = 0; input_regdst = 0; input_regwr = 0;
      input_memrd = 0; input_memwr = 0; input_memtoreg = 0;
      input_exmem_regwr = 0; input_exmem_rw = 0;
      input_exmem_result = 0; input_memwb_regwr = 0;
      input_memwb_rw = 0; input_memwb_data = 0;
   endtask

   function automatic logic [31:0] ext_model(logic [15:0] i, logic e);
      int signed s;
      s = e ? int'($signed(i)) : int'(i);
      return 32'(s);
   endfunction

   function automatic logic [31:0] fwd_model(logic [4:0] src,
                                            logic [31:0] bus);
`ifdef EX_FORWARD_EN
      if (src != 0 && input_exmem_regwr && input_exmem_rw == src)
         return input_exmem_result;
      if (src != 0 && input_memwb_regwr && input_memwb_rw == src)
         return input_memwb_data;
`endif
      return bus;
   endfunction

   function automatic logic hz_model();
      logic [4:0] srcs [2];
      logic h;
      srcs[0] = input_rs;
      srcs[1] = input_rt;
      h = 0;
      if (!input_valid) return 0;
      foreach (srcs[k]) begin
`ifdef EX_FORWARD_EN
         if (m.valid && m.memrd && m.rw != 0 && m.rw == srcs[k]) h = 1;
`else
         if (srcs[k] != 0 && m.valid && m.regwr && m.rw == srcs[k]) h = 1;
         if (srcs[k] != 0 && input_exmem_regwr &&
             input_exmem_rw == srcs[k]) h = 1;
`endif
      end
      return h;
   endfunction

   function automatic st_t next_model(logic hz);
      st_t n;
      n = '0;
      if (input_reset || input_flush) return n;
      if (input_stall) return m;
      if (hz) return n;
      n.busa = input_busa;
      n.busb = input_busb;
      n.imm = ext_model(input_imm16, input_extop);
      n.rs = input_rs;
      n.rt = input_rt;
      n.rw = input_regdst ? input_rd : input_rt;
      n.aluctr = input_aluctr;
      n.alusrc = input_alusrc;
      n.regwr = input_regwr;
      n.memrd = input_memrd;
      n.memwr = input_memwr;
      n.memtoreg = input_memtoreg;
      n.valid = input_valid;
      return n;
   endfunction

   task automatic test_reset;
      clear_in;
      input_busa = 32'hA5A5A5A5; input_busb = 32'h5A5A0001;
      input_imm16 = 16'hFFFF; input_extop = 1;
      input_rs = 3; input_rt = 4; input_rd = 7; input_regdst = 1;
      input_aluctr = 5; input_regwr = 1; input_memwr = 1;
      input_memtoreg = 1; input_valid = 1; input_reset = 1;
      for (int c = 0; c < 2; c++) begin
         tick;
         total++;
         if ({out_alu_a, out_alu_b, out_store_data} !== '0) begin
            bad++;
            $display("FAIL reset_data got=%h/%h/%h exp=0",
                     out_alu_a, out_alu_b, out_store_data);
         end
         total++;
         if ({out_aluctr, out_rw, out_regwr, out_memrd, out_memwr,
              out_memtoreg, out_valid, out_hazard_stall} !== '0) begin
            bad++;
            $display("FAIL reset_ctrl got=%b exp=0",
                     {out_aluctr, out_rw, out_regwr, out_memrd, out_memwr,
                      out_memtoreg, out_valid, out_hazard_stall});
         end
      end
      input_reset = 0;
      tick;
      total++;
      if ({out_valid, out_rw, out_aluctr, out_regwr, out_memwr} !==
          {1'b1, 5'd7, 3'd5, 1'b1, 1'b1}) begin
         bad++;
         $display("FAIL reset_first_capture got v=%b rw=%0d ctr=%0d exp v=1 rw=7 ctr=5",
                  out_valid, out_rw, out_aluctr);
      end
      total++;
      if (out_alu_a !== 32'hA5A5A5A5 || out_alu_b !== 32'h5A5A0001) begin
         bad++;
         $display("FAIL reset_first_ops got=%h/%h exp=a5a5a5a5/5a5a0001",
                  out_alu_a, out_alu_b);
      end
   endtask

   task automatic test_imm;
      clear_in;
      input_valid = 1; input_imm16 = 16'hFFF0;
      input_alusrc = 1; input_extop = 1;
      tick;
      total++;
      if (out_alu_b !== 32'hFFFFFFF0) begin
         bad++;
         $display("FAIL imm_sext got=%h exp=fffffff0", out_alu_b);
      end
      input_extop = 0;
      tick;
      total++;
      if (out_alu_b !== 32'h0000FFF0) begin
         bad++;
         $display("FAIL imm_zext got=%h exp=0000fff0", out_alu_b);
      end
   endtask

   task automatic test_forward;
      clear_in;
      input_valid = 1; input_rs = 8; input_busa = 32'h5555;
      tick;
      clear_in;
      input_exmem_regwr = 1; input_exmem_rw = 8;
      input_exmem_result = 32'h11;
      input_memwb_regwr = 1; input_memwb_rw = 8;
      input_memwb_data = 32'h22;
      #1;
`ifdef EX_FORWARD_EN
      total++;
      if (out_alu_a !== 32'h11) begin
         bad++;
         $display("FAIL fwd_exmem got=%h exp=11", out_alu_a);
      end
      input_exmem_regwr = 0;
      #1;
      total++;
      if (out_alu_a !== 32'h22) begin
         bad++;
         $display("FAIL fwd_memwb got=%h exp=22", out_alu_a);
      end
`else
      total++;
      if (out_alu_a !== 32'h5555) begin
         bad++;
         $display("FAIL nofwd_a got=%h exp=5555", out_alu_a);
      end
`endif
      clear_in;
      input_valid = 1; input_busa = 32'h77;
      tick;
      input_valid = 0;
      input_exmem_regwr = 1; input_exmem_result = 32'h11;
      input_memwb_regwr = 1; input_memwb_data = 32'h22;
      #1;
      total++;
      if (out_alu_a !== 32'h77) begin
         bad++;
         $display("FAIL fwd_r0 got=%h exp=77", out_alu_a);
      end
   endtask

   task automatic test_hazard;
      clear_in;
      input_valid = 1; input_rt = 9; input_regwr = 1;
`ifdef EX_FORWARD_EN
      input_memrd = 1; input_memtoreg = 1; input_alusrc = 1;
`else
      input_rd = 9; input_regdst = 1;
`endif
      tick;
      clear_in;
      input_valid = 1; input_rs = 1; input_rt = 9; input_rd = 10;
      input_regdst = 1; input_regwr = 1;
      input_busa = 100; input_busb = 200;
      #1;
      total++;
      if (out_hazard_stall !== 1'b1) begin
         bad++;
         $display("FAIL hz_detect got=%b exp=1", out_hazard_stall);
      end
      tick;
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("FAIL hz_bubble got=%b exp=0", out_valid);
      end
`ifndef EX_FORWARD_EN
      input_exmem_regwr = 1; input_exmem_rw = 9;
      #1;
      total++;
      if (out_hazard_stall !== 1'b1) begin
         bad++;
         $display("FAIL hz_exmem got=%b exp=1", out_hazard_stall);
      end
      tick;
      input_exmem_regwr = 0;
`else
      input_memwb_regwr = 1; input_memwb_rw = 9;
      input_memwb_data = 32'hDEAD;
`endif
      #1;
      total++;
      if (out_hazard_stall !== 1'b0) begin
         bad++;
         $display("FAIL hz_clear got=%b exp=0", out_hazard_stall);
      end
      tick;
      total++;
      if (out_valid !== 1'b1 || out_rw !== 5'd10 || out_alu_a !== 32'd100) begin
         bad++;
         $display("FAIL hz_reissue got v=%b rw=%0d a=%h exp v=1 rw=10 a=64",
                  out_valid, out_rw, out_alu_a);
      end
`ifdef EX_FORWARD_EN
      total++;
      if (out_alu_b !== 32'hDEAD) begin
         bad++;
         $display("FAIL hz_fwd_b got=%h exp=dead", out_alu_b);
      end
`else
      total++;
      if (out_alu_b !== 32'd200) begin
         bad++;
         $display("FAIL hz_b got=%h exp=c8", out_alu_b);
      end
`endif
   endtask

   task automatic test_flush_stall;
      clear_in;
      input_valid = 1; input_rs = 2; input_rt = 3; input_rd = 4;
      input_busa = 32'h1111; input_busb = 32'h2222;
      input_regdst = 1; input_regwr = 1; input_aluctr = 3;
      tick;
      input_stall = 1;
      for (int c = 0; c < 3; c++) begin
         input_busa = $urandom;
         input_rs = 5'($urandom_range(1, 31));
         input_rd = 5'($urandom_range(11, 31));
         input_aluctr = 3'($urandom);
         tick;
         total++;
         if (out_alu_a !== 32'h1111 || out_rw !== 5'd4 ||
             out_valid !== 1'b1 || out_aluctr !== 3'd3) begin
            bad++;
            $display("FAIL stall_hold c=%0d got a=%h rw=%0d v=%b ctr=%0d",
                     c, out_alu_a, out_rw, out_valid, out_aluctr);
         end
      end
      input_flush = 1;
      tick;
      total++;
      if (out_valid !== 1'b0 || out_rw !== 5'd0 || out_alu_a !== 32'd0) begin
         bad++;
         $display("FAIL flush_over_stall got v=%b rw=%0d a=%h exp 0",
                  out_valid, out_rw, out_alu_a);
      end
      input_flush = 0;
      input_stall = 0;
   endtask

   task automatic test_store;
      clear_in;
      input_valid = 1; input_memwr = 1; input_alusrc = 1;
      input_extop = 1; input_imm16 = 16'h0010;
      input_rt = 5; input_busb = 32'h1234;
      tick;
      input_valid = 0;
      input_exmem_regwr = 1; input_exmem_rw = 5;
      input_exmem_result = 32'hABCD;
      #1;
`ifdef EX_FORWARD_EN
      total++;
      if (out_store_data !== 32'hABCD) begin
         bad++;
         $display("FAIL store_fwd got=%h exp=abcd", out_store_data);
      end
`else
      total++;
      if (out_store_data !== 32'h1234) begin
         bad++;
         $display("FAIL store_data got=%h exp=1234", out_store_data);
      end
`endif
      total++;
      if (out_alu_b !== 32'h10) begin
         bad++;
         $display("FAIL store_alu_b got=%h exp=10", out_alu_b);
      end
   endtask

   task automatic test_random;
      st_t nxt;
      logic hz;
      clear_in;
      input_reset = 1;
      tick;
      m = '0;
      for (int c = 0; c < 400; c++) begin
         input_reset = ($urandom_range(0, 49) == 0);
         input_flush = ($urandom_range(0, 15) == 0);
         input_stall = ($urandom_range(0, 7) == 0);
         input_valid = ($urandom_range(0, 3) != 0);
         input_busa = $urandom; input_busb = $urandom;
         input_imm16 = 16'($urandom); input_extop = 1'($urandom);
         input_rs = 5'($urandom_range(0, 3));
         input_rt = 5'($urandom_range(0, 3));
         input_rd = 5'($urandom_range(0, 3));
         input_aluctr = 3'($urandom); input_alusrc = 1'($urandom);
         input_regdst = 1'($urandom); input_regwr = 1'($urandom);
         input_memrd = 1'($urandom); input_memwr = 1'($urandom);
         input_memtoreg = 1'($urandom);
         input_exmem_regwr = 1'($urandom);
         input_exmem_rw = 5'($urandom_range(0, 3));
         input_exmem_result = $urandom;
         input_memwb_regwr = 1'($urandom);
         input_memwb_rw = 5'($urandom_range(0, 3));
         input_memwb_data = $urandom;
         #1;
         hz = hz_model();
         total++;
         if (out_hazard_stall !== hz) begin
            bad++;
            $display("FAIL rnd_hazard c=%0d got=%b exp=%b",
                     c, out_hazard_stall, hz);
         end
         total++;
         if (out_alu_a !== fwd_model(m.rs, m.busa)) begin
            bad++;
            $display("FAIL rnd_alu_a c=%0d got=%h exp=%h",
                     c, out_alu_a, fwd_model(m.rs, m.busa));
         end
         total++;
         if (out_alu_b !== (m.alusrc ? m.imm : fwd_model(m.rt, m.busb))) begin
            bad++;
            $display("FAIL rnd_alu_b c=%0d got=%h", c, out_alu_b);
         end
         total++;
         if (out_store_data !== fwd_model(m.rt, m.busb)) begin
            bad++;
            $display("FAIL rnd_store c=%0d got=%h exp=%h",
                     c, out_store_data, fwd_model(m.rt, m.busb));
         end
         total++;
         if ({out_aluctr, out_rw, out_regwr, out_memrd, out_memwr,
              out_memtoreg, out_valid} !==
             {m.aluctr, m.rw, m.regwr, m.memrd, m.memwr,
              m.memtoreg, m.valid}) begin
            bad++;
            $display("FAIL rnd_ctrl c=%0d got ctr=%0d rw=%0d v=%b exp ctr=%0d rw=%0d v=%b",
                     c, out_aluctr, out_rw, out_valid,
                     m.aluctr, m.rw, m.valid);
         end
         nxt = next_model(hz);
         tick;
         m = nxt;
      end
   endtask

   initial begin
      clear_in;
      tick;
      test_reset;
      test_imm;
      test_forward;
      test_hazard;
      test_flush_stall;
      test_store;
      test_random;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
